// File: rtl/irq_trap_ctrl_pkg.sv
// Purpose: shared constants for the interrupt/trap sequencer (CSR addresses, FSM state encoding).
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Contents:
//    CSR_MIE / CSR_MIP   machine interrupt-enable / interrupt-pending CSR addresses
//    trap_state_t        trap sequencer states IDLE..EXIT (3-bit encoding)
package irq_trap_ctrl_pkg;

   localparam logic [11:0] CSR_MIE = 12'h304;
   localparam logic [11:0] CSR_MIP = 12'h344;

   typedef enum logic [2:0] {
      TRAP_IDLE    = 3'd0,
      TRAP_DRAIN   = 3'd1,
      TRAP_ENTRY   = 3'd2,
      TRAP_HANDLER = 3'd3,
      TRAP_EXIT    = 3'd4
   } trap_state_t;

endpackage

// File: rtl/irq_trap_ctrl_prio_enc.sv
// Purpose: fixed-priority encoder, the lowest set request bit wins.
// Latency: combinational, 0 cycles.
// Backpressure: none; the output follows the input every cycle.
// Ports:
//    req   in   NUM_IRQ  qualified request vector
//    vld   out  1        at least one request set
//    idx   out  4        index of the lowest set bit (0 when vld is low)
module irq_prio_enc #(
   parameter int NUM_IRQ = 8
) (
   input  logic [NUM_IRQ-1:0] req,
   output logic               vld,
   output logic [3:0]         idx
);

   always_comb begin
      vld = |req;
      idx = 4'd0;
      // Scan from the top down so the lowest set bit is the last assignment.
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (req[i]) idx = 4'(i);
      end
   end

endmodule

// File: rtl/irq_trap_ctrl.sv
// Purpose: interrupt arbiter and trap sequencer for the machine-mode CSR file.
// Latency: qualified request -> DRAIN next cycle -> ENTRY pulse the cycle after pipe_drained.
// Backpressure: waits in DRAIN (pipe_flush held) until pipe_drained; no inputs are ever stalled.
// Ports:
//    clk, rst_n                          clock, asynchronous active-low reset
//    irq_src[NUM_IRQ]                    interrupt request lines
//    int_mstatus_mie                     global enable from mstatus
//    CSR_IDX_wb/CSRdata_wb/CSRen_wb      CSR writeback (mie is written at CSR_MIE)
//    mie_val/mip_val                     zero-extended mie and pending vectors for the CSR read mux
//    pipe_flush/pipe_drained             drain handshake with the pipeline
//    mret_valid                          mret retiring
//    trap_entry_en/trap_exit_en          one-cycle pulses to the CSR file
//    int_index                           winning source, held until the next arbitration
//    pc_redirect                         fetch loads trap_entry_pc (with trap_entry_en)
//    in_handler                          high while in HANDLER
// Build option: IRQ_EDGE_LATCH_EN selects rising-edge latched pending bits instead of level sources.
module irq_trap_ctrl
   import irq_trap_ctrl_pkg::*;
#(
   parameter int                 NUM_IRQ = 8,
   parameter logic [NUM_IRQ-1:0] MIE_RST = {NUM_IRQ{1'b1}}
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_IRQ-1:0] irq_src,
   input  logic               int_mstatus_mie,
   input  logic [11:0]        CSR_IDX_wb,
   input  logic [31:0]        CSRdata_wb,
   input  logic               CSRen_wb,
   output logic [31:0]        mie_val,
   output logic [31:0]        mip_val,
   output logic               pipe_flush,
   input  logic               pipe_drained,
   input  logic               mret_valid,
   output logic               trap_entry_en,
   output logic               trap_exit_en,
   output logic [3:0]         int_index,
   output logic               pc_redirect,
   output logic               in_handler
);

   trap_state_t        state, state_nxt;
   logic [NUM_IRQ-1:0] mie;
   logic [NUM_IRQ-1:0] pending;
   logic [NUM_IRQ-1:0] req;
   logic               win_vld;
   logic [3:0]         win_idx;
   logic               take_irq;

   // Upper writeback bits have no mie storage behind them.
   logic unused_csr_bits;
   assign unused_csr_bits = ^CSRdata_wb[31:NUM_IRQ];

   // ---------------- mie register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mie <= MIE_RST;
      end else if (CSRen_wb && (CSR_IDX_wb == CSR_MIE)) begin
         mie <= CSRdata_wb[NUM_IRQ-1:0];
      end
   end

   // ---------------- pending vector ----------------
`ifdef IRQ_EDGE_LATCH_EN
   logic [NUM_IRQ-1:0] irq_prev;
   logic [NUM_IRQ-1:0] irq_rise;
   logic [NUM_IRQ-1:0] pend_clr;

   assign irq_rise = irq_src & ~irq_prev;

   // Only the source being entered is acknowledged; others stay latched.
   always_comb begin
      pend_clr = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         pend_clr[i] = (state == TRAP_ENTRY) && (int_index == 4'(i));
      end
   end

   // A rise coinciding with the clear is ORed in after it, so it survives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_prev <= '0;
         pending  <= '0;
      end else begin
         irq_prev <= irq_src;
         pending  <= (pending & ~pend_clr) | irq_rise;
      end
   end
`else
   assign pending = irq_src;
`endif

   assign req     = pending & mie;
   assign mie_val = {{(32-NUM_IRQ){1'b0}}, mie};
   assign mip_val = {{(32-NUM_IRQ){1'b0}}, pending};

   irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio_enc (
      .req (req),
      .vld (win_vld),
      .idx (win_idx)
   );

   assign take_irq = win_vld && int_mstatus_mie;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= TRAP_IDLE;
         int_index <= 4'd0;
      end else begin
         state <= state_nxt;
         // Winner is committed on entry to DRAIN; later source/mie changes cannot cancel it.
         if (state == TRAP_IDLE && take_irq) int_index <= win_idx;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         // An interrupt beats a simultaneous mret; that mret is flushed.
         TRAP_IDLE: begin
            if (take_irq)        state_nxt = TRAP_DRAIN;
            else if (mret_valid) state_nxt = TRAP_EXIT;
         end
         TRAP_DRAIN:   if (pipe_drained) state_nxt = TRAP_ENTRY;
         TRAP_ENTRY:   state_nxt = TRAP_HANDLER;
         TRAP_HANDLER: if (mret_valid) state_nxt = TRAP_EXIT;
         TRAP_EXIT:    state_nxt = TRAP_IDLE;
         default:      state_nxt = TRAP_IDLE;
      endcase
   end

   // Moore outputs.
   always_comb begin
      pipe_flush    = (state == TRAP_DRAIN) || (state == TRAP_ENTRY);
      trap_entry_en = (state == TRAP_ENTRY);
      pc_redirect   = (state == TRAP_ENTRY);
      trap_exit_en  = (state == TRAP_EXIT);
      in_handler    = (state == TRAP_HANDLER);
   end

endmodule

// File: tb/tb_irq_trap_ctrl.sv
module tb_irq_trap_ctrl;

   logic        clk;
   logic        rst_n;
   logic [7:0]  irq_src;
   logic        int_mstatus_mie;
   logic [11:0] CSR_IDX_wb;
   logic [31:0] CSRdata_wb;
   logic        CSRen_wb;
   logic [31:0] mie_val;
   logic [31:0] mip_val;
   logic        pipe_flush;
   logic        pipe_drained;
   logic        mret_valid;
   logic        trap_entry_en;
   logic        trap_exit_en;
   logic [3:0]  int_index;
   logic        pc_redirect;
   logic        in_handler;

   int checks   = 0;
   int failures = 0;

   irq_trap_ctrl #(.NUM_IRQ(8), .MIE_RST(8'hFF)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .irq_src         (irq_src),
      .int_mstatus_mie (int_mstatus_mie),
      .CSR_IDX_wb      (CSR_IDX_wb),
      .CSRdata_wb      (CSRdata_wb),
      .CSRen_wb        (CSRen_wb),
      .mie_val         (mie_val),
      .mip_val         (mip_val),
      .pipe_flush      (pipe_flush),
      .pipe_drained    (pipe_drained),
      .mret_valid      (mret_valid),
      .trap_entry_en   (trap_entry_en),
      .trap_exit_en    (trap_exit_en),
      .int_index       (int_index),
      .pc_redirect     (pc_redirect),
      .in_handler      (in_handler)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle; outputs are sampled and inputs driven 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // {pipe_flush, trap_entry_en, pc_redirect, trap_exit_en, in_handler}
   function automatic logic [31:0] ctl();
      return {27'd0, pipe_flush, trap_entry_en, pc_redirect, trap_exit_en, in_handler};
   endfunction

   initial begin
      rst_n = 1'b0;
      irq_src = 8'h00;
      int_mstatus_mie = 1'b0;
      CSR_IDX_wb = 12'h000;
      CSRdata_wb = 32'h0;
      CSRen_wb = 1'b0;
      pipe_drained = 1'b0;
      mret_valid = 1'b0;
      #12;
      chk("rst_ctl", ctl(), 32'h0);
      chk("rst_idx", {28'd0, int_index}, 32'h0);
      chk("rst_mie", mie_val, 32'hFF);
      step();
      rst_n = 1'b1;
      step();
      step();
      // Test 1: idle after reset
      chk("idle_ctl", ctl(), 32'h0);
      chk("idle_mie", mie_val, 32'hFF);
      chk("idle_mip", mip_val, 32'h0);

`ifndef IRQ_EDGE_LATCH_EN
      // Test 2: minimum latency, lowest bit of 0x24 is 2
      int_mstatus_mie = 1'b1;
      pipe_drained = 1'b1;
      irq_src = 8'h24;
      #1;
      chk("c0_ctl", ctl(), 32'h0);
      chk("c0_mip", mip_val, 32'h24);
      step();
      chk("c1_ctl", ctl(), 32'b10000);
      chk("c1_idx", {28'd0, int_index}, 32'd2);
      step();
      chk("c2_ctl", ctl(), 32'b11100);
      step();
      chk("c3_ctl", ctl(), 32'b00001);
      step();
      chk("c4_ctl", ctl(), 32'b00001);

      // Test 5: mret -> EXIT -> IDLE -> DRAIN again (source still high)
      mret_valid = 1'b1;
      step();
      mret_valid = 1'b0;
      chk("exit_ctl", ctl(), 32'b00010);
      pipe_drained = 1'b0;
      step();
      chk("post_exit_idle", ctl(), 32'h0);
      step();
      chk("redrain_ctl", ctl(), 32'b10000);

      // Test 3: stall in DRAIN, source drops, entry keeps index 2
      irq_src = 8'h00;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_ctl", ctl(), 32'b10000);
      end
      pipe_drained = 1'b1;
      step();
      chk("late_entry_ctl", ctl(), 32'b11100);
      chk("late_entry_idx", {28'd0, int_index}, 32'd2);
      step();
      chk("late_hdl_ctl", ctl(), 32'b00001);
      mret_valid = 1'b1;
      step();
      mret_valid = 1'b0;
      step();
      step();
      chk("back_idle", ctl(), 32'h0);

      // mret alone in IDLE -> EXIT
      mret_valid = 1'b1;
      step();
      mret_valid = 1'b0;
      chk("idle_mret", ctl(), 32'b00010);
      step();

      // Test 4: mie = 0x80, MIE=0 blocks, then index 7
      CSRen_wb = 1'b1;
      CSR_IDX_wb = 12'h304;
      CSRdata_wb = 32'h0000_0080;
      int_mstatus_mie = 1'b0;
      step();
      CSRen_wb = 1'b0;
      CSRdata_wb = 32'h0;
      chk("mie_write", mie_val, 32'h80);
      irq_src = 8'h81;
      step();
      chk("mie0_ctl", ctl(), 32'h0);
      chk("mie0_mip", mip_val, 32'h81);
      step();
      chk("mie0_ctl2", ctl(), 32'h0);
      // Interrupt and mret together: interrupt wins
      int_mstatus_mie = 1'b1;
      mret_valid = 1'b1;
      step();
      mret_valid = 1'b0;
      chk("irq_vs_mret", ctl(), 32'b10000);
      chk("idx7", {28'd0, int_index}, 32'd7);
      pipe_drained = 1'b0;
      step();

      // Test 7: reset in DRAIN
      rst_n = 1'b0;
      #1;
      chk("midrst_ctl", ctl(), 32'h0);
      chk("midrst_idx", {28'd0, int_index}, 32'h0);
      chk("midrst_mie", mie_val, 32'hFF);
      pipe_drained = 1'b1;
      step();
      chk("midrst_hold", ctl(), 32'h0);
      irq_src = 8'h00;
      rst_n = 1'b1;
      step();
      chk("after_rst", ctl(), 32'h0);
`else
      // Test 6: edge latched pending
      int_mstatus_mie = 1'b1;
      pipe_drained = 1'b1;
      irq_src = 8'h10;
      step();
      irq_src = 8'h00;
      chk("e_mip_set", mip_val, 32'h10);
      step();
      chk("e_drain", ctl(), 32'b10000);
      chk("e_idx", {28'd0, int_index}, 32'd4);
      step();
      chk("e_entry", ctl(), 32'b11100);
      step();
      chk("e_hdl", ctl(), 32'b00001);
      chk("e_clr", mip_val, 32'h0);
      irq_src = 8'h10;
      step();
      irq_src = 8'h00;
      step();
      chk("e_held1", mip_val, 32'h10);
      step();
      chk("e_held2", mip_val, 32'h10);
      chk("e_still_hdl", ctl(), 32'b00001);
      mret_valid = 1'b1;
      step();
      mret_valid = 1'b0;
      chk("e_exit", ctl(), 32'b00010);
      step();
      step();
      chk("e_redrain", ctl(), 32'b10000);
      step();
      chk("e_reentry", ctl(), 32'b11100);
      step();
      chk("e_reclr", mip_val, 32'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
